// File: rtl/i281_fetch_stage.sv
// i281_fetch_stage: single-slot instruction fetch stage for the i281 CPU.
//
// Fetches 16-bit instruction words from a 16-word combinational program ROM into one
// registered output slot. The slot hands off to decode through a valid/ready pair, and
// execute can redirect the fetch with a one-cycle pulse.
//
// Ports
//   clock          in   rising-edge clock
//   reset_n        in   asynchronous active-low reset
//   imem_words     in   16 ROM words, word k on bits [16k+15:16k]
//   run_en         in   1 = fetch, 0 = stop fetching and drain the slot
//   redirect_valid in   taken branch/jump pulse from execute
//   redirect_pc    in   branch target word address
//   decode_ready   in   decode can accept instr_out this cycle
//   instr_out      out  registered fetched instruction
//   instr_pc       out  word address instr_out came from
//   instr_valid    out  instr_out/instr_pc hold an unconsumed instruction
//   pc             out  next word address to fetch
//   running        out  high while in RUN
//   fetch_count    out  saturating count of accepted instructions
module i281_fetch_stage #(
    parameter logic [3:0] RESET_PC = 4'd0
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic [255:0] imem_words,
    input  logic         run_en,
    input  logic         redirect_valid,
    input  logic [3:0]   redirect_pc,
    input  logic         decode_ready,
    output logic [15:0]  instr_out,
    output logic [3:0]   instr_pc,
    output logic         instr_valid,
    output logic [3:0]   pc,
    output logic         running,
    output logic [7:0]   fetch_count
);

    typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

    state_e      state_q, state_d;
    logic [15:0] instr_out_q, instr_out_d;
    logic [3:0]  instr_pc_q, instr_pc_d;
    logic        instr_valid_q, instr_valid_d;
    logic [3:0]  pc_q, pc_d;
    logic [7:0]  fetch_count_q, fetch_count_d;

    logic        accept;
    logic        slot_free;
    logic        do_fetch;
    logic [15:0] fetch_word;

    assign accept     = instr_valid_q & decode_ready;
    assign slot_free  = ~instr_valid_q | accept;
    assign fetch_word = imem_words[{pc_q, 4'b0000} +: 16];

    // State register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (run_en) state_d = StRun;
            end
            StRun: begin
                // A redirect empties the slot, so there is nothing left to drain.
                if (!run_en) begin
                    state_d = (instr_valid_q && !accept && !redirect_valid) ? StDrain : StIdle;
                end
            end
            StDrain: begin
                if (accept || redirect_valid || !instr_valid_q) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Output logic.
    always_comb begin
        running  = (state_q == StRun);
        do_fetch = (state_q == StRun) && run_en && slot_free && !redirect_valid;
    end

    // Datapath next-state: redirect beats fetch, fetch beats plain consume, else hold.
    always_comb begin
        instr_out_d   = instr_out_q;
        instr_pc_d    = instr_pc_q;
        instr_valid_d = instr_valid_q;
        pc_d          = pc_q;
        fetch_count_d = fetch_count_q;

        if (accept && fetch_count_q != 8'hFF) fetch_count_d = fetch_count_q + 8'd1;

        if (redirect_valid) begin
            instr_valid_d = 1'b0;
            pc_d          = redirect_pc;
        end else if (do_fetch) begin
            instr_out_d   = fetch_word;
            instr_pc_d    = pc_q;
            instr_valid_d = 1'b1;
            pc_d          = pc_q + 4'd1;
        end else if (accept) begin
            instr_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            instr_out_q   <= 16'h0000;
            instr_pc_q    <= 4'h0;
            instr_valid_q <= 1'b0;
            pc_q          <= RESET_PC;
            fetch_count_q <= 8'h00;
        end else begin
            instr_out_q   <= instr_out_d;
            instr_pc_q    <= instr_pc_d;
            instr_valid_q <= instr_valid_d;
            pc_q          <= pc_d;
            fetch_count_q <= fetch_count_d;
        end
    end

    assign instr_out   = instr_out_q;
    assign instr_pc    = instr_pc_q;
    assign instr_valid = instr_valid_q;
    assign pc          = pc_q;
    assign fetch_count = fetch_count_q;

endmodule

// File: tb/tb_i281_fetch_stage.sv
// Self-checking bench for i281_fetch_stage: directed vector table, hand-written
// multi-cycle sequences, and randomized stimulus against a behavioural model.
module tb_i281_fetch_stage;

    logic         clock;
    logic         reset_n;
    logic [255:0] imem_words;
    logic         run_en;
    logic         redirect_valid;
    logic [3:0]   redirect_pc;
    logic         decode_ready;
    logic [15:0]  instr_out;
    logic [3:0]   instr_pc;
    logic         instr_valid;
    logic [3:0]   pc;
    logic         running;
    logic [7:0]   fetch_count;

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] words [16];

    i281_fetch_stage #(.RESET_PC(4'd0)) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .imem_words     (imem_words),
        .run_en         (run_en),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .decode_ready   (decode_ready),
        .instr_out      (instr_out),
        .instr_pc       (instr_pc),
        .instr_valid    (instr_valid),
        .pc             (pc),
        .running        (running),
        .fetch_count    (fetch_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Packed view: {instr_out, instr_pc, instr_valid, pc, running, fetch_count}
    function automatic logic [33:0] pack(input logic [15:0] o, input logic [3:0] ip,
                                         input logic v, input logic [3:0] p,
                                         input logic r, input logic [7:0] c);
        return {o, ip, v, p, r, c};
    endfunction

    function automatic logic [33:0] dut_view();
        return pack(instr_out, instr_pc, instr_valid, pc, running, fetch_count);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic load_rom();
        for (int k = 0; k < 16; k++) imem_words[16*k +: 16] = words[k];
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset_n = 1'b0;
        run_en = 1'b0; redirect_valid = 1'b0; redirect_pc = 4'h0; decode_ready = 1'b0;
        #2;
        reset_n = 1'b1;
    endtask

    // Behavioural model: spec rules applied once per clock edge.
    int          m_state; // 0 idle, 1 run, 2 drain
    logic [15:0] m_out;
    logic [3:0]  m_ipc;
    logic        m_v;
    int          m_pc;
    int          m_cnt;

    task automatic model_reset();
        m_state = 0; m_out = 16'h0; m_ipc = 4'h0; m_v = 1'b0; m_pc = 0; m_cnt = 0;
    endtask

    task automatic model_step(input logic run, input logic rv, input logic [3:0] rpc,
                              input logic rd);
        bit acc;
        int nstate;
        acc = m_v && rd;
        nstate = m_state;
        if (m_state == 0 && run) nstate = 1;
        if (m_state == 1 && !run) nstate = (m_v && !acc && !rv) ? 2 : 0;
        if (m_state == 2 && (acc || rv || !m_v)) nstate = 0;
        if (acc && m_cnt < 255) m_cnt = m_cnt + 1;
        if (rv) begin
            m_v = 1'b0; m_pc = rpc;
        end else if (m_state == 1 && run && (!m_v || acc)) begin
            m_out = words[m_pc]; m_ipc = 4'(m_pc); m_v = 1'b1; m_pc = (m_pc + 1) % 16;
        end else if (acc) begin
            m_v = 1'b0;
        end
        m_state = nstate;
    endtask

    typedef struct {
        logic        run;
        logic        rv;
        logic [3:0]  rpc;
        logic        rd;
        logic [15:0] out;
        logic [3:0]  ipc;
        logic        v;
        logic [3:0]  pc;
        logic        run_o;
        logic [7:0]  cnt;
    } vec_t;

    vec_t vecs [10];

    initial begin
        logic [7:0] cnt_snap;
        bit found;

        vecs[0] = '{1'b1, 1'b0, 4'h0, 1'b1, 16'h0000, 4'h0, 1'b0, 4'h0, 1'b1, 8'd0};
        vecs[1] = '{1'b1, 1'b0, 4'h0, 1'b1, 16'h3000, 4'h0, 1'b1, 4'h1, 1'b1, 8'd0};
        vecs[2] = '{1'b1, 1'b0, 4'h0, 1'b1, 16'h3001, 4'h1, 1'b1, 4'h2, 1'b1, 8'd1};
        vecs[3] = '{1'b1, 1'b0, 4'h0, 1'b1, 16'h3002, 4'h2, 1'b1, 4'h3, 1'b1, 8'd2};
        vecs[4] = '{1'b1, 1'b0, 4'h0, 1'b1, 16'h3003, 4'h3, 1'b1, 4'h4, 1'b1, 8'd3};
        vecs[5] = '{1'b1, 1'b1, 4'hC, 1'b0, 16'h3003, 4'h3, 1'b0, 4'hC, 1'b1, 8'd3};
        vecs[6] = '{1'b1, 1'b0, 4'h0, 1'b0, 16'h300C, 4'hC, 1'b1, 4'hD, 1'b1, 8'd3};
        vecs[7] = '{1'b1, 1'b0, 4'h0, 1'b0, 16'h300C, 4'hC, 1'b1, 4'hD, 1'b1, 8'd3};
        vecs[8] = '{1'b0, 1'b0, 4'h0, 1'b1, 16'h300C, 4'hC, 1'b0, 4'hD, 1'b0, 8'd4};
        vecs[9] = '{1'b0, 1'b0, 4'h0, 1'b1, 16'h300C, 4'hC, 1'b0, 4'hD, 1'b0, 8'd4};

        for (int k = 0; k < 16; k++) words[k] = 16'h3000 + 16'(k);
        load_rom();
        reset_n = 1'b1;
        do_reset();
        #1;
        check("reset_state", 64'(dut_view()), 64'(pack(16'h0, 4'h0, 1'b0, 4'h0, 1'b0, 8'd0)));

        // Table: start-up, redirect to C, stall, accept while stopping.
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            run_en = vecs[i].run; redirect_valid = vecs[i].rv;
            redirect_pc = vecs[i].rpc; decode_ready = vecs[i].rd;
            @(posedge clock); #1;
            check($sformatf("vec%0d", i), 64'(dut_view()),
                  64'(pack(vecs[i].out, vecs[i].ipc, vecs[i].v, vecs[i].pc,
                           vecs[i].run_o, vecs[i].cnt)));
        end

        // Stall on 3005 for three cycles, then a single accept.
        do_reset();
        @(negedge clock);
        run_en = 1'b1; decode_ready = 1'b1;
        found = 0;
        for (int c = 0; c < 40 && !found; c++) begin
            @(posedge clock); #1;
            if (instr_valid && instr_out == 16'h3005) found = 1;
        end
        check("reach_3005", 64'(found), 64'(1));
        @(negedge clock);
        decode_ready = 1'b0;
        cnt_snap = fetch_count;
        check("count_at_3005", 64'(cnt_snap), 64'(5));
        for (int c = 0; c < 3; c++) begin
            @(posedge clock); #1;
            check($sformatf("stall%0d", c), 64'({instr_out, pc, instr_valid, fetch_count}),
                  64'({16'h3005, 4'h6, 1'b1, 8'd5}));
        end
        @(negedge clock);
        decode_ready = 1'b1;
        @(posedge clock); #1;
        check("stall_release", 64'({instr_out, instr_pc, fetch_count}),
              64'({16'h3006, 4'h6, 8'd6}));
        @(negedge clock);
        decode_ready = 1'b0;
        @(posedge clock); #1;
        check("single_count", 64'({instr_out, fetch_count}), 64'({16'h3006, 8'd6}));

        // Drain: stop with a held instruction; run_en in DRAIN is ignored.
        @(negedge clock);
        run_en = 1'b0;
        @(posedge clock); #1;
        check("drain_enter", 64'(dut_view()), 64'(pack(16'h3006, 4'h6, 1'b1, 4'h7, 1'b0, 8'd6)));
        @(negedge clock);
        run_en = 1'b1;
        @(posedge clock); #1;
        check("drain_ignores_run", 64'(dut_view()),
              64'(pack(16'h3006, 4'h6, 1'b1, 4'h7, 1'b0, 8'd6)));
        @(negedge clock);
        run_en = 1'b0; decode_ready = 1'b1;
        @(posedge clock); #1;
        check("drain_accept", 64'(dut_view()), 64'(pack(16'h3006, 4'h6, 1'b0, 4'h7, 1'b0, 8'd7)));
        @(posedge clock); #1;
        check("idle_no_fetch", 64'(dut_view()), 64'(pack(16'h3006, 4'h6, 1'b0, 4'h7, 1'b0, 8'd7)));

        // Full-speed stream with wrap from 15 back to 0.
        do_reset();
        @(negedge clock);
        run_en = 1'b1; decode_ready = 1'b1;
        @(posedge clock); #1;
        check("valid_not_yet", 64'(instr_valid), 64'(0));
        for (int n = 0; n < 18; n++) begin
            @(posedge clock); #1;
            check($sformatf("stream%0d", n), 64'({instr_valid, instr_out, instr_pc}),
                  64'({1'b1, 16'h3000 + 16'(n % 16), 4'(n % 16)}));
        end

        // Saturation.
        repeat (300) @(posedge clock);
        #1;
        check("count_sat", 64'(fetch_count), 64'(255));
        repeat (3) @(posedge clock);
        #1;
        check("count_sat_hold", 64'(fetch_count), 64'(255));

        // Asynchronous reset between edges.
        @(posedge clock);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_reset", 64'(dut_view()), 64'(pack(16'h0, 4'h0, 1'b0, 4'h0, 1'b0, 8'd0)));
        @(negedge clock);
        reset_n = 1'b1;

        // Randomized run against the model.
        for (int k = 0; k < 16; k++) words[k] = 16'($urandom);
        load_rom();
        do_reset();
        model_reset();
        for (int c = 0; c < 600; c++) begin
            @(negedge clock);
            run_en         = ($urandom_range(0, 9) != 0);
            redirect_valid = ($urandom_range(0, 9) == 0);
            redirect_pc    = 4'($urandom);
            decode_ready   = ($urandom_range(0, 9) < 6);
            model_step(run_en, redirect_valid, redirect_pc, decode_ready);
            @(posedge clock); #1;
            check($sformatf("rand%0d", c), 64'(dut_view()),
                  64'(pack(m_out, m_ipc, m_v, 4'(m_pc), m_state == 1, 8'(m_cnt))));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
